// File: rtl/regfile_sched.sv
// regfile_sched: owns the 15-entry Y86-64 register file and sequences
// decode-stage operand reads against writeback-stage dual writes through a
// single internal write port. Writeback has priority over reads. When both
// write ports target the same register, the E write lands first and the M
// write second, so valM is the final value (popq %rsp behaviour).
module regfile_sched #(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] RSP_RESET = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [3:0]        dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic              rd_done,
  output logic              busy
);

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR_E = 2'd1,
    S_WR_M = 2'd2,
    S_RD   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_regs [0:14];
  logic [3:0]        r_dst_e;
  logic [3:0]        r_dst_m;
  logic [DATA_W-1:0] r_val_e;
  logic [DATA_W-1:0] r_val_m;
  logic [3:0]        r_src_a;
  logic [3:0]        r_src_b;
  logic [DATA_W-1:0] r_val_a;
  logic [DATA_W-1:0] r_val_b;
  logic              r_rd_done;
  logic              w_wb_xfer;
  logic              w_rd_xfer;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  // Handshakes are purely combinational so a requester sees acceptance in the same cycle.
  assign wb_ready  = (r_state == S_IDLE);
  assign rd_ready  = (r_state == S_IDLE) && !wb_valid;
  assign busy      = (r_state != S_IDLE);
  assign w_wb_xfer = wb_valid && wb_ready;
  assign w_rd_xfer = rd_valid && rd_ready;

  // ID 0xF has no storage; it always reads as zero.
  assign w_rd_a = (r_src_a == RNONE) ? {DATA_W{1'b0}} : r_regs[r_src_a];
  assign w_rd_b = (r_src_b == RNONE) ? {DATA_W{1'b0}} : r_regs[r_src_b];

  assign valA    = r_val_a;
  assign valB    = r_val_b;
  assign rd_done = r_rd_done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: a writeback skips any port whose destination is RNONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (wb_valid) begin
          if (dstE != RNONE) begin
            w_next = S_WR_E;
          end else if (dstM != RNONE) begin
            w_next = S_WR_M;
          end else begin
            w_next = S_IDLE;
          end
        end else if (rd_valid) begin
          w_next = S_RD;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WR_E: begin
        if (r_dst_m != RNONE) begin
          w_next = S_WR_M;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WR_M:  w_next = S_IDLE;
      S_RD:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Capture request fields on transfer so requesters may move on immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dst_e <= 4'h0;
      r_dst_m <= 4'h0;
      r_val_e <= {DATA_W{1'b0}};
      r_val_m <= {DATA_W{1'b0}};
      r_src_a <= 4'h0;
      r_src_b <= 4'h0;
    end else if (w_wb_xfer) begin
      r_dst_e <= dstE;
      r_dst_m <= dstM;
      r_val_e <= valE;
      r_val_m <= valM;
    end else if (w_rd_xfer) begin
      r_src_a <= srcA;
      r_src_b <= srcB;
    end
  end

  // Register array with its single write port, driven from the WR_E / WR_M states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        r_regs[i] <= (i == 4) ? RSP_RESET : {DATA_W{1'b0}};
      end
    end else begin
      case (r_state)
        S_WR_E: if (r_dst_e != RNONE) r_regs[r_dst_e] <= r_val_e;
        S_WR_M: if (r_dst_m != RNONE) r_regs[r_dst_m] <= r_val_m;
        default: ;
      endcase
    end
  end

  // Operand results: updated only on RD completion, held otherwise; rd_done pulses once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val_a   <= {DATA_W{1'b0}};
      r_val_b   <= {DATA_W{1'b0}};
      r_rd_done <= 1'b0;
    end else if (r_state == S_RD) begin
      r_val_a   <= w_rd_a;
      r_val_b   <= w_rd_b;
      r_rd_done <= 1'b1;
    end else begin
      r_rd_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_sched.sv
// Self-checking bench for regfile_sched: directed scenarios plus randomized
// writeback/read traffic, checked against an array model of the register file.
module tb_regfile_sched;

  localparam logic [63:0] RSP_RST = 64'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [3:0]  dstE = 4'hF;
  logic [63:0] valE = 64'h0;
  logic [3:0]  dstM = 4'hF;
  logic [63:0] valM = 64'h0;
  logic        rd_valid = 1'b0;
  logic        rd_ready;
  logic [3:0]  srcA = 4'h0;
  logic [3:0]  srcB = 4'h0;
  logic [63:0] valA;
  logic [63:0] valB;
  logic        rd_done;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] model [0:15];

  regfile_sched #(.DATA_W(64), .RSP_RESET(RSP_RST)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .rd_done(rd_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model[i] = 64'h0;
    model[4] = RSP_RST;
  endtask

  // Writeback reference: E applied then M; ID 0xF is never stored.
  task automatic model_wb(input logic [3:0] de, input logic [63:0] ve,
                          input logic [3:0] dm, input logic [63:0] vm);
    if (de != 4'hF) model[de] = ve;
    if (dm != 4'hF) model[dm] = vm;
  endtask

  task automatic do_wb(input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm);
    int n;
    int busy_cnt;
    int exp_busy;
    wb_valid = 1'b1; dstE = de; valE = ve; dstM = dm; valM = vm;
    #1;
    n = 0;
    while (!wb_ready && n < 20) begin
      @(posedge clk); #2; n++;
    end
    check_val("wb_ready", {63'h0, wb_ready}, 64'h1);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    model_wb(de, ve, dm, vm);
    exp_busy = ((de != 4'hF) ? 1 : 0) + ((dm != 4'hF) ? 1 : 0);
    busy_cnt = 0;
    while (busy && busy_cnt < 10) begin
      busy_cnt++;
      @(posedge clk); #1;
    end
    check_val("wb_busy_cycles", 64'(busy_cnt), 64'(exp_busy));
  endtask

  task automatic finish_rd(input logic [3:0] a, input logic [3:0] b);
    int n;
    n = 0;
    while (!rd_done && n < 5) begin
      @(posedge clk); #1; n++;
    end
    check_val("rd_done", {63'h0, rd_done}, 64'h1);
    check_val("valA", valA, model[a]);
    check_val("valB", valB, model[b]);
    @(posedge clk); #1;
    check_val("rd_done_pulse", {63'h0, rd_done}, 64'h0);
    check_val("valA_hold", valA, model[a]);
  endtask

  task automatic do_rd(input logic [3:0] a, input logic [3:0] b);
    int n;
    rd_valid = 1'b1; srcA = a; srcB = b;
    #1;
    n = 0;
    while (!rd_ready && n < 20) begin
      @(posedge clk); #2; n++;
    end
    check_val("rd_ready", {63'h0, rd_ready}, 64'h1);
    @(posedge clk); #1;
    rd_valid = 1'b0;
    finish_rd(a, b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    model[15] = 64'h0;
    #3;
    check_val("rst_busy", {63'h0, busy}, 64'h0);
    check_val("rst_rd_done", {63'h0, rd_done}, 64'h0);
    check_val("rst_valA", valA, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_rd(4'h4, 4'h0);
    do_wb(4'h2, 64'hAAAA, 4'h3, 64'h5555);
    do_rd(4'h2, 4'h3);
    do_wb(4'h4, 64'h10, 4'h4, 64'h20);
    do_rd(4'h4, 4'h2);
    check_val("m_wins", valA, 64'h20);

    // Writeback and read requested together: writeback goes first.
    wb_valid = 1'b1; dstE = 4'h7; valE = 64'h7777_0000_1234; dstM = 4'hF; valM = 64'h0;
    rd_valid = 1'b1; srcA = 4'h7; srcB = 4'h3;
    #1;
    check_val("same_wb_ready", {63'h0, wb_ready}, 64'h1);
    check_val("same_rd_ready", {63'h0, rd_ready}, 64'h0);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    model_wb(4'h7, 64'h7777_0000_1234, 4'hF, 64'h0);
    check_val("same_rd_blocked", {63'h0, rd_ready}, 64'h0);
    n = 0;
    while (!rd_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check_val("same_rd_wait", 64'(n), 64'h1);
    @(posedge clk); #1;
    rd_valid = 1'b0;
    finish_rd(4'h7, 4'h3);

    do_wb(4'hF, 64'hBAD, 4'hF, 64'hBAD);
    do_rd(4'hF, 4'h4);
    do_rd(4'h2, 4'h3);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_wb(4'($urandom_range(0, 15)), {$urandom, $urandom},
              4'($urandom_range(0, 15)), {$urandom, $urandom});
      end else begin
        do_rd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
    end

    do_wb(4'h9, 64'hDEAD_BEEF, 4'hF, 64'h0);
    do_rd(4'h9, 4'h9);

    // Reset during WR_E drops the whole writeback.
    wb_valid = 1'b1; dstE = 4'h5; valE = 64'hFFFF; dstM = 4'h6; valM = 64'h6666;
    @(posedge clk); #1;
    wb_valid = 1'b0;
    check_val("wre_busy", {63'h0, busy}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_busy", {63'h0, busy}, 64'h0);
    check_val("arst_valA", valA, 64'h0);
    check_val("arst_valB", valB, 64'h0);
    check_val("arst_rd_done", {63'h0, rd_done}, 64'h0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_rd(4'h5, 4'h6);
    do_rd(4'h4, 4'h9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
